// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HOLD} fetch_state_t;
  localparam int PC_INC = 4;
  localparam int PC_PLUS8 = 8;
  localparam int NOP_INSTR = 0;
endpackage

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: IF/ID pipeline register with enable and synchronous clear
module fetch_decode_reg #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] instrIn,
  input  logic [N-1:0] pcPlus8In,
  input  logic         validIn,
  output logic [N-1:0] instrD,
  output logic [N-1:0] pcPlus8D,
  output logic         validD
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      instrD   <= '0;
      pcPlus8D <= '0;
      validD   <= 1'b0;
    end else if (clr) begin
      instrD   <= '0;
      pcPlus8D <= '0;
      validD   <= 1'b0;
    end else if (en) begin
      instrD   <= instrIn;
      pcPlus8D <= pcPlus8In;
      validD   <= validIn;
    end
endmodule

// File: rtl/fetch.sv
// fetch: PC selection, single-outstanding imem handshake and IF/ID register
module fetch
  import fetch_pkg::*;
#(
  parameter int N = 24,
  parameter logic [N-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         StallF,
  input  logic         StallD,
  input  logic         FlushD,
  input  logic         BranchTakenE,
  input  logic [N-1:0] ALUResultE,
  input  logic         PCSrcW,
  input  logic [N-1:0] ResultW,
  output logic         IMemReq,
  output logic [N-1:0] IMemAddr,
  input  logic         IMemReady,
  input  logic         IMemValid,
  input  logic [N-1:0] IMemRData,
  output logic [N-1:0] InstrD,
  output logic [N-1:0] PCPlus8D,
  output logic         ValidD,
  output logic         FetchBusy
);
  fetch_state_t state, stateNext;
  logic [N-1:0] pcF, pcNext, bufData, target, deliverData;
  logic squash, squashNext, redirect, dataOk, deliverDirect, deliverBuf, deliver, canGo;

  assign redirect      = BranchTakenE | PCSrcW;
  assign target        = BranchTakenE ? ALUResultE : ResultW;
  assign canGo         = !StallF && !StallD;
  assign dataOk        = state == F_WAIT && IMemValid && !squash && !redirect;
  assign deliverDirect = dataOk && canGo;
  assign deliverBuf    = state == F_HOLD && !redirect && canGo;
  assign deliver       = deliverDirect | deliverBuf;
  assign deliverData   = state == F_HOLD ? bufData : IMemRData;
  assign pcNext        = redirect ? target : deliver ? pcF + N'(PC_INC) : pcF;
  assign IMemReq       = state == F_REQ;
  assign IMemAddr      = pcF;
  assign FetchBusy     = state != F_HOLD && !dataOk;

  always_comb begin
    stateNext  = state;
    squashNext = squash;
    case (state)
      F_IDLE: stateNext = F_REQ;
      F_REQ: begin
        stateNext  = IMemReady ? F_WAIT : F_REQ;
        squashNext = IMemReady && redirect;
      end
      F_WAIT: begin
        stateNext  = !IMemValid ? F_WAIT : (squash || redirect || canGo) ? F_REQ : F_HOLD;
        squashNext = IMemValid ? 1'b0 : squash | redirect;
      end
      default: stateNext = (redirect || canGo) ? F_REQ : F_HOLD;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= F_IDLE;
      pcF     <= RESET_PC;
      squash  <= 1'b0;
      bufData <= '0;
    end else begin
      state  <= stateNext;
      pcF    <= pcNext;
      squash <= squashNext;
      if (dataOk && !canGo) bufData <= IMemRData;
    end

  fetch_decode_reg #(.N(N)) u_decodeReg (
    .clk       (clk),
    .rst       (rst),
    .en        (!StallD),
    .clr       (FlushD),
    .instrIn   (deliver ? deliverData : N'(NOP_INSTR)),
    .pcPlus8In (deliver ? pcF + N'(PC_PLUS8) : '0),
    .validIn   (deliver),
    .instrD    (InstrD),
    .pcPlus8D  (PCPlus8D),
    .validD    (ValidD)
  );
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed checks of the fetch stage handshake, redirects and IF/ID control
module tb_fetch;
  logic clk = 1'b0, rst = 1'b0;
  logic StallF = 0, StallD = 0, FlushD = 0, BranchTakenE = 0, PCSrcW = 0;
  logic [23:0] ALUResultE = '0, ResultW = '0, IMemRData = '0;
  logic IMemReady = 0, IMemValid = 0;
  logic IMemReq, ValidD, FetchBusy;
  logic [23:0] IMemAddr, InstrD, PCPlus8D;
  int tests = 0, fails = 0;

  fetch dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .BranchTakenE(BranchTakenE), .ALUResultE(ALUResultE), .PCSrcW(PCSrcW), .ResultW(ResultW),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemValid(IMemValid),
    .IMemRData(IMemRData), .InstrD(InstrD), .PCPlus8D(PCPlus8D), .ValidD(ValidD),
    .FetchBusy(FetchBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_instr", InstrD, 24'h0);
    chk("rst_valid", 24'(ValidD), 24'h0);
    chk("rst_req", 24'(IMemReq), 24'h0);
    chk("rst_busy", 24'(FetchBusy), 24'h1);
    rst = 1;
    step();
    chk("t1_req", 24'(IMemReq), 24'h1);
    chk("t1_addr", IMemAddr, 24'h0);
    IMemReady = 1;
    step();
    chk("t1_wait_req", 24'(IMemReq), 24'h0);
    IMemReady = 0; IMemValid = 1; IMemRData = 24'hA1B2C3;
    #1 chk("t1_busy_arrive", 24'(FetchBusy), 24'h0);
    step();
    chk("t1_instr", InstrD, 24'hA1B2C3);
    chk("t1_pc8", PCPlus8D, 24'h8);
    chk("t1_valid", 24'(ValidD), 24'h1);
    chk("t1_addr2", IMemAddr, 24'h4);
    IMemValid = 0; IMemReady = 1;
    step();
    chk("t1_bubble", 24'(ValidD), 24'h0);
    chk("t1_bubble_instr", InstrD, 24'h0);
    IMemReady = 0; IMemValid = 1; IMemRData = 24'h112233;
    step();
    chk("t1_instr2", InstrD, 24'h112233);
    chk("t1_pc8_2", PCPlus8D, 24'd12);
    IMemValid = 0;
    // StallD held across arrival: data goes to buffer, IF/ID holds
    IMemReady = 1; StallD = 1;
    step();
    chk("st_hold_instr", InstrD, 24'h112233);
    IMemReady = 0; IMemValid = 1; IMemRData = 24'h555555;
    step();
    IMemValid = 0;
    chk("st_hold_valid", 24'(ValidD), 24'h1);
    chk("st_no_req", 24'(IMemReq), 24'h0);
    chk("st_busy", 24'(FetchBusy), 24'h0);
    step();
    chk("st_no_req2", 24'(IMemReq), 24'h0);
    chk("st_pc", IMemAddr, 24'h8);
    chk("st_hold_instr2", InstrD, 24'h112233);
    StallD = 0;
    step();
    chk("st_buf_instr", InstrD, 24'h555555);
    chk("st_buf_pc8", PCPlus8D, 24'h10);
    chk("st_next_addr", IMemAddr, 24'hC);
    chk("st_req", 24'(IMemReq), 24'h1);
    // branch while waiting squashes the in-flight response
    IMemReady = 1;
    step();
    IMemReady = 0; BranchTakenE = 1; ALUResultE = 24'h40;
    step();
    BranchTakenE = 0; IMemValid = 1; IMemRData = 24'hDEAD00;
    #1 chk("br_busy_squash", 24'(FetchBusy), 24'h1);
    step();
    IMemValid = 0;
    chk("br_discard", 24'(ValidD), 24'h0);
    chk("br_addr", IMemAddr, 24'h40);
    chk("br_req", 24'(IMemReq), 24'h1);
    IMemReady = 1;
    step();
    IMemReady = 0; IMemValid = 1; IMemRData = 24'h777777;
    step();
    IMemValid = 0;
    chk("br_instr", InstrD, 24'h777777);
    chk("br_pc8", PCPlus8D, 24'h48);
    // branch beats writeback PC write
    BranchTakenE = 1; ALUResultE = 24'h40; PCSrcW = 1; ResultW = 24'h80;
    step();
    BranchTakenE = 0; PCSrcW = 0;
    chk("pri_addr", IMemAddr, 24'h40);
    IMemReady = 1;
    step();
    IMemReady = 0; IMemValid = 1; IMemRData = 24'h123456;
    step();
    IMemValid = 0;
    chk("fl_pre_valid", 24'(ValidD), 24'h1);
    FlushD = 1; StallD = 1;
    step();
    FlushD = 0; StallD = 0;
    chk("fl_instr", InstrD, 24'h0);
    chk("fl_valid", 24'(ValidD), 24'h0);
    chk("fl_pc8", PCPlus8D, 24'h0);
    // wrap-around at top of address space
    PCSrcW = 1; ResultW = 24'hFFFFFC;
    step();
    PCSrcW = 0;
    chk("wr_addr", IMemAddr, 24'hFFFFFC);
    IMemReady = 1;
    step();
    IMemReady = 0; IMemValid = 1; IMemRData = 24'hABCDEF;
    step();
    IMemValid = 0;
    chk("wr_instr", InstrD, 24'hABCDEF);
    chk("wr_pc8", PCPlus8D, 24'h000004);
    chk("wr_next_addr", IMemAddr, 24'h0);
    IMemReady = 1;
    step();
    IMemReady = 0;
    rst = 0;
    #1;
    chk("ar_instr", InstrD, 24'h0);
    chk("ar_valid", 24'(ValidD), 24'h0);
    chk("ar_pc8", PCPlus8D, 24'h0);
    chk("ar_req", 24'(IMemReq), 24'h0);
    @(negedge clk);
    rst = 1;
    step();
    chk("ar_restart_req", 24'(IMemReq), 24'h1);
    chk("ar_restart_addr", IMemAddr, 24'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
